neuron_accumulator: RTL and testbench
=====================================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter N_INPUTS, default 4, SHALL set the number of products per neuron evaluation (range 1..256).
REQ-003 Parameter ACC_W, default 24, SHALL set the signed accumulator width (at least 16 + clog2(N_INPUTS) + 1).
REQ-004 Parameter SHIFT, default 0, SHALL set the arithmetic right shift (fixed-point scaling) applied before activation.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  a product is presented on mul.
REQ-008 in_ready  output  1  block accepts a product this cycle.
REQ-009 mul  input  16  signed product from the upstream 8x8 multiplier.
REQ-010 bias  input  16  signed neuron bias, sampled with the first product of each evaluation.
REQ-011 out_valid  output  1  an activation result is available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  8  signed activation: ReLU, saturated to 0..127.
REQ-014 acc_out  output  ACC_W  signed raw sum, bias plus all products, unshifted.

Function
REQ-015 The FSM SHALL have two states, ACCUM and HOLD; in_ready SHALL equal (state==ACCUM) and out_valid SHALL equal (state==HOLD).
REQ-016 A product SHALL be accepted only on a cycle with in_valid && in_ready at the rising edge.
REQ-017 On an accepted product with count==0, acc SHALL load sext(bias) + sext(mul).
REQ-018 On an accepted product with count>0, acc SHALL load acc + sext(mul).
REQ-019 count SHALL increment on each accepted product, with range 0..N_INPUTS-1.
REQ-020 When the accepted product has count==N_INPUTS-1, count SHALL return to 0 and the FSM SHALL go to HOLD.
- out_valid therefore asserts the cycle after the Nth product is accepted (latency 1 cycle).
REQ-021 Cycles with in_valid low in ACCUM SHALL leave acc and count unchanged (bubbles allowed).
REQ-022 In HOLD, out_data and acc_out SHALL be stable, and in_valid SHALL be ignored.
REQ-023 In HOLD, out_valid && out_ready SHALL return the FSM to ACCUM on the next edge.
- The first product of the next evaluation is accepted no earlier than the cycle after the handshake (no same-cycle pass-through).
REQ-024 The block SHALL compute pre = acc >>> SHIFT (sign-preserving).
REQ-025 out_data SHALL be 0 if pre<0, 127 if pre>127, else pre[7:0].
REQ-026 out_data and acc_out SHALL be derived from registered acc only.
REQ-027 Accumulation SHALL be two's-complement.
- Overflow cannot occur with a legal ACC_W; behaviour with an illegal ACC_W is wrap-around.
REQ-028 With N_INPUTS==1, every accepted product SHALL load bias+mul and go to HOLD.
REQ-029 bias changes after the first accepted product of an evaluation SHALL NOT affect that evaluation.

Reset
REQ-030 While rst_n==0, the block SHALL hold state=ACCUM, count=0 and acc=0.
- Outputs during reset: in_ready=1, out_valid=0, out_data=0, acc_out=0.
REQ-031 Reset asserted mid-evaluation or in HOLD SHALL discard partial sums and any pending result.
- After rst_n deasserts, the next accepted product is treated as count==0.

Verification (N_INPUTS=4, ACC_W=24, SHIFT=0 unless stated)
REQ-032 Basic sum: bias=0, mul=4,1,2,3 on consecutive cycles -> out_valid the cycle after the 4th; acc_out=10, out_data=10.
REQ-033 Saturation: bias=100, mul=4096 x4 -> acc_out=16484, out_data=127.
REQ-034 ReLU: bias=-5, mul=1,1,1,1 -> acc_out=-1, out_data=0.
- Extreme case: bias=0, mul=16384 x4 -> acc_out=65536, out_data=127.
REQ-035 Backpressure and bubbles:
- Stimulus: in_valid gapped 2 cycles between products; after the 4th product, out_ready held low 3 cycles while in_valid stays high with mul=7.
- Required: out_valid held, in_ready=0, results unchanged, mul=7 not absorbed; after the handshake the next evaluation starts fresh from bias.
REQ-036 Reset mid-vector: accept mul=50,60, pulse rst_n low 1 cycle, then bias=2 with mul=1,2,3,4 -> acc_out=12, out_data=12.
REQ-037 Scaling: SHIFT=2, bias=0, mul=-3 x4 -> acc_out=-12, pre=-3, out_data=0.
- Positive case: mul=100 x4 -> acc_out=400, pre=100, out_data=100.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// Product/result handshake bundle for the neuron accumulator.
// master drives products and result acceptance; slave is the accumulator.
interface neuron_accumulator_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      mul;
    logic [15:0]      bias;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [ACC_W-1:0] acc_out;

    modport master (
        output in_valid, mul, bias, out_ready,
        input  in_ready, out_valid, out_data, acc_out
    );

    modport slave (
        input  in_valid, mul, bias, out_ready,
        output in_ready, out_valid, out_data, acc_out
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Bias + N-product accumulator with shift, ReLU and 0..127 saturation.
// Result is held until the downstream handshake, then a new sum starts.
module neuron_accumulator #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    neuron_accumulator_if.slave bus
);
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic signed [ACC_W-1:0] SAT = ACC_W'(127);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           count;
    logic signed [ACC_W-1:0] acc, acc_n, pre;
    logic signed [ACC_W-1:0] mul_x, bias_x;
    logic                    take, last;

    assign mul_x  = {{(ACC_W-16){bus.mul[15]}}, bus.mul};
    assign bias_x = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
    assign take   = bus.in_valid && (state == ACCUM);
    assign last   = (count == CW'(N_INPUTS-1));
    assign acc_n  = ((count == '0) ? bias_x : acc) + mul_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (take && last)  state_n = HOLD;
            HOLD:  if (bus.out_ready) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (take) begin
            acc   <= acc_n;
            count <= last ? '0 : count + CW'(1);
        end
    end

    // Activation reads only the registered sum, so HOLD outputs are stable.
    assign pre = acc >>> SHIFT;

    always_comb begin
        bus.out_data = pre[7:0];
        unique case (1'b1)
            pre[ACC_W-1]: bus.out_data = 8'd0;
            (pre > SAT):  bus.out_data = 8'd127;
            default:      bus.out_data = pre[7:0];
        endcase
    end

    assign bus.acc_out   = acc;
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
endmodule

// File: tb/tb_neuron_accumulator.sv
// Random + directed bench for neuron_accumulator (SHIFT 0 and SHIFT 2 copies).
// A queue-based neuron model is checked against both DUTs every cycle.
module tb_neuron_accumulator;
    localparam int N = 4;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    neuron_accumulator_if #(.ACC_W(AW)) ifa ();
    neuron_accumulator_if #(.ACC_W(AW)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.mul       = ifa.mul;
    assign ifb.bias      = ifa.bias;
    assign ifb.out_ready = ifa.out_ready;

    neuron_accumulator #(.N_INPUTS(N), .ACC_W(AW), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    neuron_accumulator #(.N_INPUTS(N), .ACC_W(AW), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [AW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int act(input int x, input int sh);
        int p;
        p = x >>> sh;
        if (p < 0) return 0;
        if (p > 127) return 127;
        return p;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: products of the current evaluation plus the bias seen with the first.
    int q[$];
    int m_bias = 0;
    int m_acc = 0;
    bit m_hold = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_acc = 0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (ifa.out_ready) begin
                m_hold = 1'b0;
                q.delete();
            end
        end else if (ifa.in_valid) begin
            if (q.size() == 0) m_bias = int'($signed(ifa.bias));
            q.push_back(int'($signed(ifa.mul)));
            m_acc = m_bias;
            foreach (q[i]) m_acc += q[i];
            if (q.size() == N) m_hold = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(ifa.in_ready), int'(!m_hold));
        chk("out_valid", int'(ifa.out_valid), int'(m_hold));
        chk("acc_out", sx(ifa.acc_out), m_acc);
        chk("out_data", int'(ifa.out_data), act(m_acc, 0));
        chk("out_valid_s2", int'(ifb.out_valid), int'(m_hold));
        chk("acc_out_s2", sx(ifb.acc_out), m_acc);
        chk("out_data_s2", int'(ifb.out_data), act(m_acc, 2));
    end

    task automatic drive(input bit v, input int m, input int b, input bit r);
        @(posedge clk);
        #2;
        ifa.in_valid  = v;
        ifa.mul       = 16'(m);
        ifa.bias      = 16'(b);
        ifa.out_ready = r;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifa.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifa.out_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic eval4(input string name, input int b,
                         input int m0, input int m1, input int m2, input int m3,
                         input int gap, input int hold_cyc,
                         input int e_acc, input int e_out, input int e_out2);
        int m[4];
        m = '{m0, m1, m2, m3};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, m[i], b, 1'b0);
            for (int g = 0; g < gap; g++) drive(1'b0, 0, b, 1'b0);
        end
        for (int h = 0; h < hold_cyc; h++) drive(1'b1, 7, b + 1, 1'b0);
        if (hold_cyc == 0) drive(1'b0, 0, 0, 1'b0);
        wait_result(name);
        chk({name, "_acc"}, sx(ifa.acc_out), e_acc);
        chk({name, "_out"}, int'(ifa.out_data), e_out);
        chk({name, "_out_s2"}, int'(ifb.out_data), e_out2);
        drive(1'b0, 0, 0, 1'b1);
        drive(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        ifa.in_valid = 1'b0;
        ifa.mul = '0;
        ifa.bias = '0;
        ifa.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(ifa.in_ready), 1);
        chk("rst_out_valid", int'(ifa.out_valid), 0);
        chk("rst_out_data", int'(ifa.out_data), 0);
        chk("rst_acc_out", sx(ifa.acc_out), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        eval4("basic", 0, 4, 1, 2, 3, 0, 0, 10, 10, 2);
        eval4("sat", 100, 4096, 4096, 4096, 4096, 0, 0, 16484, 127, 127);
        eval4("relu", -5, 1, 1, 1, 1, 0, 0, -1, 0, 0);
        eval4("extreme", 0, 16384, 16384, 16384, 16384, 0, 0, 65536, 127, 127);
        eval4("bp", 3, 10, 20, 30, 40, 2, 3, 103, 103, 25);
        eval4("fresh", 1, 1, 1, 1, 1, 0, 0, 5, 5, 1);
        eval4("shneg", 0, -3, -3, -3, -3, 0, 0, -12, 0, 0);
        eval4("shpos", 0, 100, 100, 100, 100, 0, 0, 400, 127, 100);

        drive(1'b1, 50, 0, 1'b0);
        drive(1'b1, 60, 0, 1'b0);
        @(posedge clk);
        #2;
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        eval4("rstmid", 2, 1, 2, 3, 4, 0, 0, 12, 12, 3);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 65535)), ($urandom_range(0, 2) != 0));
        end
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
